// File: rtl/scan_pkg.sv
// Shared types and default timing constants for the scan sequencer and its step generator.
package scan_pkg;

  localparam int unsigned LINES_W = 24;
  localparam int unsigned RESO_W  = 8;
  localparam int unsigned CNT_W   = 32;

  localparam int unsigned DEF_STEP_HIGH_CYC = 100;
  localparam int unsigned DEF_STEP_LOW_CYC  = 100;
  localparam int unsigned DEF_SETTLE_CYC    = 50;
  localparam int unsigned DEF_LINE_TIMEOUT  = 1000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_INTEG,
    S_STEP,
    S_SETTLE,
    S_DONE,
    S_ERR
  } scan_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HIGH,
    P_LOW
  } step_phase_e;

endpackage

// File: rtl/step_pulse_gen.sv
// Emits count_i+1 step pulses, each HIGH_CYC high followed by LOW_CYC low,
// then a one-cycle done_o; abort_i drops everything immediately.
module step_pulse_gen
  import scan_pkg::*;
#(
  parameter int unsigned HIGH_CYC = DEF_STEP_HIGH_CYC,
  parameter int unsigned LOW_CYC  = DEF_STEP_LOW_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [RESO_W-1:0] count_i,
  output logic              step_o,
  output logic              busy_o,
  output logic              done_o
);

  step_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [RESO_W-1:0] left_q, left_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    phase_d = phase_q;
    cyc_d   = cyc_q + CNT_W'(1);
    left_d  = left_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    if (abort_i) begin
      phase_d = P_IDLE;
      cyc_d   = '0;
      left_d  = '0;
    end else begin
      case (phase_q)
        P_IDLE: begin
          cyc_d = '0;
          if (start_i) begin
            phase_d = P_HIGH;
            left_d  = count_i;
            step_d  = 1'b1;
          end
        end
        P_HIGH: begin
          step_d = 1'b1;
          if (cyc_q == CNT_W'(HIGH_CYC - 1)) begin
            phase_d = P_LOW;
            cyc_d   = '0;
            step_d  = 1'b0;
          end
        end
        P_LOW: begin
          if (cyc_q == CNT_W'(LOW_CYC - 1)) begin
            cyc_d = '0;
            if (left_q == '0) begin
              phase_d = P_IDLE;
              done_d  = 1'b1;
            end else begin
              phase_d = P_HIGH;
              left_d  = left_q - RESO_W'(1);
              step_d  = 1'b1;
            end
          end
        end
        default: phase_d = P_IDLE;
      endcase
    end
    busy_d = (phase_d != P_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= P_IDLE;
      cyc_q   <= '0;
      left_q  <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      left_q  <= left_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step_o = step_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/scan_sequencer.sv
// Line-scan sequencer: alternates sensor integration and motor stepping for a
// latched number of lines, with abort on run falling and a readout timeout.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned STEP_HIGH_CYC = DEF_STEP_HIGH_CYC,
  parameter int unsigned STEP_LOW_CYC  = DEF_STEP_LOW_CYC,
  parameter int unsigned SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int unsigned LINE_TIMEOUT  = DEF_LINE_TIMEOUT
) (
  input  logic               clk_100M,
  input  logic               rst,
  input  logic               run,
  input  logic [LINES_W-1:0] lines,
  input  logic [RESO_W-1:0]  reso_div,
  input  logic               line_done,
  output logic               sensor_start,
  output logic               motor_step,
  output logic               motor_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LINES_W-1:0] line_cnt
);

  scan_state_e        state_q, state_d, prev_q;
  logic               run_q, hold_q;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [RESO_W-1:0]  reso_q, reso_d;
  logic [LINES_W-1:0] line_cnt_q, line_cnt_d, line_cnt_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sensor_start_q, sensor_start_d;
  logic               busy_q, busy_d;
  logic               motor_en_q, motor_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_c, abort_c, active_c, gen_start_c;
  logic               gen_busy, gen_done;

  // hold_q blocks a start until run has been seen low after reset
  assign start_c  = run & ~run_q & ~hold_q & ((state_q == S_IDLE) | (state_q == S_ERR));
  assign active_c = (state_q == S_ARM) | (state_q == S_INTEG) |
                    (state_q == S_STEP) | (state_q == S_SETTLE);
  assign abort_c  = ~run & run_q & active_c;
  assign line_cnt_inc = line_cnt_q + LINES_W'(1);

  always_comb begin
    state_d     = state_q;
    lines_d     = lines_q;
    reso_d      = reso_q;
    line_cnt_d  = line_cnt_q;
    cnt_d       = cnt_q + CNT_W'(1);
    gen_start_c = 1'b0;
    if (abort_c) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start_c) begin
            state_d    = S_ARM;
            lines_d    = lines;
            reso_d     = reso_div;
            line_cnt_d = '0;
          end
        end
        S_ARM:   state_d = (lines_q == '0) ? S_DONE : S_INTEG;
        S_INTEG: begin
          if (line_done) begin
            line_cnt_d = line_cnt_inc;
            if (line_cnt_inc == lines_q) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_STEP;
              gen_start_c = 1'b1;
            end
          end else if (cnt_q == CNT_W'(LINE_TIMEOUT - 1)) begin
            state_d = S_ERR;
          end
        end
        S_STEP:   if (gen_done && !gen_busy) state_d = S_SETTLE;
        S_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_INTEG;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;

    // Status outputs follow the state register by one cycle
    sensor_start_d = (state_q == S_INTEG) && (prev_q != S_INTEG) && !abort_c;
    busy_d         = (active_c || (state_q == S_DONE)) && !abort_c;
    motor_en_d     = busy_d;
    done_d         = (state_q == S_DONE);
    err_d          = (state_q == S_ERR) && !start_c;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q        <= S_IDLE;
      prev_q         <= S_IDLE;
      run_q          <= 1'b0;
      hold_q         <= 1'b1;
      lines_q        <= '0;
      reso_q         <= '0;
      line_cnt_q     <= '0;
      cnt_q          <= '0;
      sensor_start_q <= 1'b0;
      busy_q         <= 1'b0;
      motor_en_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= state_q;
      run_q          <= run;
      hold_q         <= hold_q & run;
      lines_q        <= lines_d;
      reso_q         <= reso_d;
      line_cnt_q     <= line_cnt_d;
      cnt_q          <= cnt_d;
      sensor_start_q <= sensor_start_d;
      busy_q         <= busy_d;
      motor_en_q     <= motor_en_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  step_pulse_gen #(
    .HIGH_CYC (STEP_HIGH_CYC),
    .LOW_CYC  (STEP_LOW_CYC)
  ) u_step (
    .clk     (clk_100M),
    .rst     (rst),
    .start_i (gen_start_c),
    .abort_i (abort_c),
    .count_i (reso_q),
    .step_o  (motor_step),
    .busy_o  (gen_busy),
    .done_o  (gen_done)
  );

  assign sensor_start = sensor_start_q;
  assign busy         = busy_q;
  assign motor_en     = motor_en_q;
  assign done         = done_q;
  assign err          = err_q;
  assign line_cnt     = line_cnt_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with short step/settle/timeout timing.
module tb_scan_sequencer;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [23:0] lines = '0;
  logic [7:0]  reso_div = '0;
  logic        line_done = 1'b0;
  logic        sensor_start, motor_step, motor_en, busy, done, err;
  logic [23:0] line_cnt;

  int errors = 0;
  int checks = 0;
  int n_sensor = 0;
  int n_step = 0;
  int n_done = 0;
  logic step_prev = 1'b0;

  always #5 clk_100M = ~clk_100M;

  scan_sequencer #(
    .STEP_HIGH_CYC (2),
    .STEP_LOW_CYC  (2),
    .SETTLE_CYC    (3),
    .LINE_TIMEOUT  (50)
  ) dut (
    .clk_100M     (clk_100M),
    .rst          (rst),
    .run          (run),
    .lines        (lines),
    .reso_div     (reso_div),
    .line_done    (line_done),
    .sensor_start (sensor_start),
    .motor_step   (motor_step),
    .motor_en     (motor_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .line_cnt     (line_cnt)
  );

  // Event counters, sampled just after each rising edge
  always @(posedge clk_100M) begin
    #1;
    if (sensor_start) n_sensor++;
    if (motor_step && !step_prev) n_step++;
    if (done) n_done++;
    step_prev = motor_step;
  end

  task automatic tick();
    @(negedge clk_100M);
  endtask

  task automatic clear_counts();
    n_sensor = 0;
    n_step   = 0;
    n_done   = 0;
  endtask

  task automatic wait_sensor(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sensor_start) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic pulse_line_done();
    repeat (4) tick();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0;
    repeat (3) tick();
    checks++; if (sensor_start !== 1'b0) begin errors++; $display("FAIL reset_sensor_start: got %b expected 0", sensor_start); end
    checks++; if (motor_step !== 1'b0) begin errors++; $display("FAIL reset_motor_step: got %b expected 0", motor_step); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL reset_motor_en: got %b expected 0", motor_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (line_cnt !== 24'd0) begin errors++; $display("FAIL reset_line_cnt: got %0d expected 0", line_cnt); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_normal_scan();
    bit ok;
    lines = 24'd3; reso_div = 8'd1;
    clear_counts();
    run = 1'b1;
    repeat (2) tick();
    checks++; if (sensor_start !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", sensor_start); end
    tick();
    checks++; if (sensor_start !== 1'b1) begin errors++; $display("FAIL latency_sensor_start: got %b expected 1", sensor_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy: got %b expected 1", busy); end
    // Inputs changed mid-scan must be ignored
    lines = 24'd7; reso_div = 8'd4;
    for (int l = 0; l < 3; l++) begin
      wait_sensor(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sensor_wait_line%0d: got timeout expected sensor_start", l); end
      pulse_line_done();
    end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL done_wait: got timeout expected done"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_with_done: got %b expected 1", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL motor_en_after_done: got %b expected 0", motor_en); end
    checks++; if (line_cnt !== 24'd3) begin errors++; $display("FAIL scan_line_cnt: got %0d expected 3", line_cnt); end
    checks++; if (n_sensor !== 3) begin errors++; $display("FAIL scan_sensor_count: got %0d expected 3", n_sensor); end
    checks++; if (n_step !== 4) begin errors++; $display("FAIL scan_step_count: got %0d expected 4", n_step); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL scan_done_count: got %0d expected 1", n_done); end
    // run held high must not restart
    repeat (10) tick();
    checks++; if (n_sensor !== 3) begin errors++; $display("FAIL no_restart_sensor: got %0d expected 3", n_sensor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_restart_busy: got %b expected 0", busy); end
    run = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_zero_lines();
    lines = 24'd0; reso_div = 8'd3;
    clear_counts();
    run = 1'b1;
    repeat (2) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
    repeat (3) tick();
    checks++; if (n_sensor !== 0) begin errors++; $display("FAIL zero_sensor_count: got %0d expected 0", n_sensor); end
    checks++; if (n_step !== 0) begin errors++; $display("FAIL zero_step_count: got %0d expected 0", n_step); end
    run = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    lines = 24'd2; reso_div = 8'd0;
    clear_counts();
    run = 1'b1;
    repeat (3) tick();
    checks++; if (sensor_start !== 1'b1) begin errors++; $display("FAIL tmo_sensor_start: got %b expected 1", sensor_start); end
    repeat (49) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL tmo_motor_en: got %b expected 0", motor_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    repeat (5) tick();
    run = 1'b0;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b expected 1", err); end
    run = 1'b1;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
    run = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    bit ok;
    lines = 24'd5; reso_div = 8'd1;
    clear_counts();
    run = 1'b1;
    wait_sensor(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_sensor_wait: got timeout expected sensor_start"); end
    pulse_line_done();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_step >= 2 && motor_step) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_step_wait: got %0d pulses expected 2", n_step); end
    run = 1'b0;
    tick();
    checks++; if (motor_step !== 1'b0) begin errors++; $display("FAIL abort_motor_step: got %b expected 0", motor_step); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL abort_motor_en: got %b expected 0", motor_en); end
    repeat (20) tick();
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
    checks++; if (line_cnt !== 24'd1) begin errors++; $display("FAIL abort_line_cnt: got %0d expected 1", line_cnt); end
    checks++; if (n_sensor !== 1) begin errors++; $display("FAIL abort_sensor_count: got %0d expected 1", n_sensor); end
  endtask

  task automatic test_reset_mid_settle();
    bit ok;
    lines = 24'd5; reso_div = 8'd0;
    clear_counts();
    run = 1'b1;
    wait_sensor(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_sensor_wait: got timeout expected sensor_start"); end
    pulse_line_done();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_step >= 1 && !motor_step) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_step_wait: got %0d pulses expected 1", n_step); end
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_settle: got %b expected 1", busy); end
    rst = 1'b1;
    repeat (2) tick();
    checks++; if ({sensor_start, motor_step, motor_en, busy, done, err} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 000000", {sensor_start, motor_step, motor_en, busy, done, err});
    end
    checks++; if (line_cnt !== 24'd0) begin errors++; $display("FAIL rst_mid_line_cnt: got %0d expected 0", line_cnt); end
    rst = 1'b0;
    clear_counts();
    repeat (10) tick();
    checks++; if (n_sensor !== 0) begin errors++; $display("FAIL rst_no_restart_sensor: got %0d expected 0", n_sensor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_restart_busy: got %b expected 0", busy); end
    run = 1'b0;
    tick();
    run = 1'b1;
    repeat (2) tick();
    checks++; if (sensor_start !== 1'b0) begin errors++; $display("FAIL rst_restart_early: got %b expected 0", sensor_start); end
    tick();
    checks++; if (sensor_start !== 1'b1) begin errors++; $display("FAIL rst_restart_sensor: got %b expected 1", sensor_start); end
    run = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_normal_scan();
    test_zero_lines();
    test_timeout();
    test_abort();
    test_reset_mid_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
